ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter that shares the single-port synchronous RAM in `soc_multicycle` between the CPU memory port and a debug/loader port. Each requester uses a req/ack handshake. The RAM side is driven with a registered enable, byte-write strobe and word address. Grants alternate round-robin. Each access is one RAM cycle, and the arbiter returns read data with the acknowledge.

## Interface
- `ADDR_W`, 10: RAM word-address width; RAM depth is 2^ADDR_W words.
- `DATA_W`, 32: data width; byte strobes are DATA_W/8.

Ports (reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `m0_req` / `m1_req`  in  1  access request; held high until ack.
- `m0_we` / `m1_we`  in  1  1 = write, 0 = read.
- `m0_addr` / `m1_addr`  in  32  byte address.
- `m0_wdata` / `m1_wdata`  in  DATA_W  write data.
- `m0_wstrb` / `m1_wstrb`  in  DATA_W/8  byte enables for writes.
- `m0_rdata` / `m1_rdata`  out  DATA_W  read data; valid only in the ack cycle.
- `m0_ack` / `m1_ack`  out  1  one-cycle completion pulse.
- `m0_err` / `m1_err`  out  1  asserted with ack when the address is out of range.
- `ram_en`  out  1  RAM access strobe.
- `ram_we`  out  DATA_W/8  per-byte write enable; all zeros for reads.
- `ram_addr`  out  ADDR_W  word address = addr[ADDR_W+1:2].
- `ram_wdata`  out  DATA_W  write data.
- `ram_rdata`  in  DATA_W  RAM read data; valid one cycle after `ram_en`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the master not granted last (`last_grant` register).
  - On a grant: latch the master's we/addr/wdata/wstrb into the request register and go to ACCESS.
- **ACCESS**
  - In range: `ram_en`=1 for exactly this cycle; `ram_we` = wstrb if we, else 0.
  - Out of range (addr[31:ADDR_W+2] ≠ 0 or addr[1:0] ≠ 0): `ram_en`=0 and the error flag is set.
  - Always go to RESP.
- **RESP**
  - Assert the granted master's ack for one cycle.
  - rdata = `ram_rdata` for an in-range read; 0 for writes and for errors.
  - err = error flag.
  - Update `last_grant`.
  - If the other master's req is high, grant it and go directly to ACCESS.
  - Otherwise go to IDLE. The just-acked master is never re-granted from RESP, because its req may still be high in this cycle.
- Requesters must keep req and request fields stable until ack and drop req in the cycle after ack. The arbiter samples the fields only at grant.
- Byte-write merging is done by the RAM via `ram_we`; the arbiter performs no read-modify-write.

## Timing
- Reset values: all acks, errs and `ram_en` = 0; `ram_we` = 0; all rdata = 0; `ram_addr`/`ram_wdata` = 0; state = IDLE; `last_grant` = m1, so m0 wins the first tie.
- Latency: req seen in IDLE at cycle N → `ram_en` at N+1 → ack at N+2.
- Throughput: two masters alternating achieve one access per 2 cycles (RESP→ACCESS). A single master achieves one access per 3 cycles.
- Both reqs rise in the same cycle: m0 acks at N+2, m1 acks at N+4; then next tie goes to m0.
- Reset asserted mid-access (ACCESS or RESP): no ack is emitted, state returns to IDLE, and a partially issued write is not retracted. Requesters must re-issue.
- RAM outputs are registered. No combinational path exists from any `m*_req` to `ram_*`.

## Structure
- Shared package `soc_pkg`:
  - FSM state typedef (`arb_state_t`).
  - `GRANT_M0`/`GRANT_M1` constants.
  - Default `ADDR_W`/`DATA_W` constants reused by `soc_multicycle` and the RAM.
- No sub-module. The 2-way round-robin pick is a few lines of combinational logic inside `ram_arbiter`.
- `soc_multicycle` instantiates `ram_arbiter` between `cpu_inst` and `ram_inst`. m1 is tied off when no loader is present.

## Test plan
- **Single write then read (m0):** write 0xDEADBEEF, wstrb 0xF, to 0x10 → `ram_we`=0xF, `ram_addr`=4 at N+1, ack at N+2; a read of 0x10 returns 0xDEADBEEF with ack, err=0.
- **Byte strobe:** m1 writes 0x000000AA with wstrb 0x1 over 0xDEADBEEF at 0x10 → a later read returns 0xDEADBEAA.
- **Simultaneous requests, both held continuously:** acks alternate m0, m1, m0, m1 at 2-cycle spacing; no master is acked twice in a row while the other is waiting.
- **Out of range:** m0 reads 0x0000_1000 with ADDR_W=10 → `ram_en` stays 0, ack and err together, rdata = 0. A misaligned address 0x2 gives the same response.
- **Reset mid-access:** assert `rst` in the ACCESS cycle → no ack is emitted, all outputs return to their reset values the next cycle, and a subsequent request completes in 2 cycles.

Source files
------------

// File: rtl/soc_pkg.sv
// soc_pkg: shared types and defaults for the multicycle SoC memory path.
// Contents:
//   arb_state_t        - ram_arbiter FSM states
//   GRANT_M0/GRANT_M1  - encodings of the arbiter grant / last_grant registers
//   ADDR_W_DEF         - default RAM word-address width
//   DATA_W_DEF         - default RAM data width
//   addr_in_range()    - word-aligned, within-RAM byte-address test
package soc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic GRANT_M0 = 1'b0;
    localparam logic GRANT_M1 = 1'b1;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    // A byte address hits the RAM only if it is word aligned and every bit
    // above the word-address field is zero.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned addr_w);
        logic [31:0] hi;
        hi = addr >> (addr_w + 2);
        return (hi == 32'd0) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between two req/ack
// masters (m0 = CPU, m1 = debug/loader) with round-robin grants.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   m*_req/we/addr/wdata/wstrb  master request (held stable until ack)
//   m*_rdata/ack/err          master response, valid in the one-cycle ack
//   ram_en/we/addr/wdata      registered RAM command
//   ram_rdata                 RAM read data, valid the cycle after ram_en
module ram_arbiter
    import soc_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [31:0]           m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_ack,
    output logic                  m0_err,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [31:0]           m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_ack,
    output logic                  m1_err,

    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int STRB_W = DATA_W / 8;

    arb_state_t           r_state;
    arb_state_t           w_next_state;

    logic                 r_last_grant;
    logic                 r_grant;
    logic                 r_we;
    logic                 r_err;
    logic                 r_ram_en;
    logic [STRB_W-1:0]    r_ram_we;
    logic [ADDR_W-1:0]    r_ram_addr;
    logic [DATA_W-1:0]    r_ram_wdata;

    logic                 w_load;
    logic                 w_sel;
    logic                 w_other_req;
    logic                 w_sel_we;
    logic [31:0]          w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [STRB_W-1:0]    w_sel_wstrb;
    logic                 w_sel_ok;
    logic                 w_resp;

    // Request of the master that is NOT currently granted; used only in RESP
    // so the just-acked master (whose req may still be high) is skipped.
    assign w_other_req = (r_grant == GRANT_M0) ? m1_req : m0_req;

    // Field mux for the master being granted this cycle.
    assign w_sel_we    = (w_sel == GRANT_M0) ? m0_we    : m1_we;
    assign w_sel_addr  = (w_sel == GRANT_M0) ? m0_addr  : m1_addr;
    assign w_sel_wdata = (w_sel == GRANT_M0) ? m0_wdata : m1_wdata;
    assign w_sel_wstrb = (w_sel == GRANT_M0) ? m0_wstrb : m1_wstrb;
    assign w_sel_ok    = addr_in_range(w_sel_addr, ADDR_W);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_sel        = GRANT_M0;
        unique case (r_state)
            IDLE: begin
                if (m0_req && m1_req) begin
                    w_load = 1'b1;
                    w_sel  = ~r_last_grant;
                end else if (m0_req) begin
                    w_load = 1'b1;
                    w_sel  = GRANT_M0;
                end else if (m1_req) begin
                    w_load = 1'b1;
                    w_sel  = GRANT_M1;
                end
            end
            ACCESS: begin
                w_next_state = RESP;
            end
            RESP: begin
                w_next_state = IDLE;
                if (w_other_req) begin
                    w_load = 1'b1;
                    w_sel  = ~r_grant;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
        if (w_load) begin
            w_next_state = ACCESS;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The RAM command is built at grant time, so ram_* are pure register
    // outputs and ram_en/ram_we pulse for exactly the ACCESS cycle.
    // A write already presented to the RAM when reset hits is not undone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_M1;
            r_grant      <= GRANT_M0;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= '0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else begin
            r_ram_en <= 1'b0;
            r_ram_we <= '0;
            if (r_state == RESP) begin
                r_last_grant <= r_grant;
            end
            if (w_load) begin
                r_grant     <= w_sel;
                r_we        <= w_sel_we;
                r_err       <= ~w_sel_ok;
                r_ram_en    <= w_sel_ok;
                r_ram_we    <= (w_sel_ok && w_sel_we) ? w_sel_wstrb : '0;
                r_ram_addr  <= w_sel_addr[ADDR_W+1:2];
                r_ram_wdata <= w_sel_wdata;
            end
        end
    end

    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

    // Responses are decoded from registered state; read data comes straight
    // from the RAM output, which is valid exactly in the RESP cycle.
    assign w_resp   = (r_state == RESP);
    assign m0_ack   = w_resp && (r_grant == GRANT_M0);
    assign m1_ack   = w_resp && (r_grant == GRANT_M1);
    assign m0_err   = m0_ack && r_err;
    assign m1_err   = m1_ack && r_err;
    assign m0_rdata = (m0_ack && !r_err && !r_we) ? ram_rdata : '0;
    assign m1_rdata = (m1_ack && !r_err && !r_we) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter with a
// behavioural byte-writable synchronous RAM attached to the RAM port.
module tb_ram_arbiter;
    import soc_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;

    logic                m0_req, m0_we, m1_req, m1_we;
    logic [31:0]         m0_addr, m1_addr;
    logic [DATA_W-1:0]   m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic [STRB_W-1:0]   m0_wstrb, m1_wstrb;
    logic                m0_ack, m0_err, m1_ack, m1_err;
    logic                ram_en;
    logic [STRB_W-1:0]   ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata = '0;

    int checks   = 0;
    int failures = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .m1_err    (m1_err),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write, byte strobes. Word 5 is seeded
    // during reset so the second master has a distinct value to read.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end else if (rst) begin
            mem[5] <= 32'h1234_5678;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    endtask

    task automatic drive_m1(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    endtask

    initial begin
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_ram_en",    {31'd0, ram_en},    32'd0);
        check("rst_ram_we",    {28'd0, ram_we},    32'd0);
        check("rst_ram_addr",  {22'd0, ram_addr},  32'd0);
        check("rst_ram_wdata", ram_wdata,          32'd0);
        check("rst_acks",      {30'd0, m0_ack, m1_ack}, 32'd0);
        check("rst_errs",      {30'd0, m0_err, m1_err}, 32'd0);
        check("rst_m0_rdata",  m0_rdata,           32'd0);
        check("rst_m1_rdata",  m1_rdata,           32'd0);
        rst = 1'b0;
        tick();

        // m0 writes 0xDEADBEEF to 0x10: ram_en at N+1, ack at N+2
        drive_m0(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        tick();
        check("wr0_ram_en",    {31'd0, ram_en},    32'd1);
        check("wr0_ram_we",    {28'd0, ram_we},    32'hF);
        check("wr0_ram_addr",  {22'd0, ram_addr},  32'd4);
        check("wr0_ram_wdata", ram_wdata,          32'hDEAD_BEEF);
        check("wr0_no_early_ack", {31'd0, m0_ack}, 32'd0);
        tick();
        check("wr0_ack",       {30'd0, m0_ack, m1_ack}, 32'b10);
        check("wr0_err",       {31'd0, m0_err},    32'd0);
        check("wr0_rdata",     m0_rdata,           32'd0);
        check("wr0_ram_en_off",{31'd0, ram_en},    32'd0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("wr0_ack_pulse", {31'd0, m0_ack},    32'd0);

        // m0 reads 0x10 back
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        check("rd0_ram_en",    {31'd0, ram_en},    32'd1);
        check("rd0_ram_we",    {28'd0, ram_we},    32'd0);
        tick();
        check("rd0_ack",       {31'd0, m0_ack},    32'd1);
        check("rd0_rdata",     m0_rdata,           32'hDEAD_BEEF);
        check("rd0_err",       {31'd0, m0_err},    32'd0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // m1 byte write 0xAA, strobe 0x1, over the same word
        drive_m1(1'b1, 1'b1, 32'h10, 32'h0000_00AA, 4'h1);
        tick();
        check("wr1_ram_we",    {28'd0, ram_we},    32'h1);
        check("wr1_ram_wdata", ram_wdata,          32'h0000_00AA);
        tick();
        check("wr1_ack",       {30'd0, m0_ack, m1_ack}, 32'b01);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        drive_m1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        tick();
        check("rd1_ack",       {31'd0, m1_ack},    32'd1);
        check("rd1_merged",    m1_rdata,           32'hDEAD_BEAA);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Both held continuously; last grant was m1 so m0 goes first
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        tick();
        check("tie_first_addr", {22'd0, ram_addr}, 32'd4);
        tick();
        check("alt_a_acks",    {30'd0, m0_ack, m1_ack}, 32'b10);
        check("alt_a_rdata",   m0_rdata,           32'hDEAD_BEAA);
        tick();
        check("alt_b_access",  {29'd0, ram_en, m0_ack, m1_ack}, 32'b100);
        check("alt_b_addr",    {22'd0, ram_addr},  32'd5);
        tick();
        check("alt_b_acks",    {30'd0, m0_ack, m1_ack}, 32'b01);
        check("alt_b_rdata",   m1_rdata,           32'h1234_5678);
        tick();
        tick();
        check("alt_c_acks",    {30'd0, m0_ack, m1_ack}, 32'b10);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        check("alt_d_acks",    {30'd0, m0_ack, m1_ack}, 32'b01);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("alt_idle_acks", {30'd0, m0_ack, m1_ack}, 32'b00);

        // Last grant m1 again: next tie goes to m0
        drive_m0(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        drive_m1(1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        tick();
        check("tie2_addr",     {22'd0, ram_addr},  32'd4);
        tick();
        check("tie2_acks",     {30'd0, m0_ack, m1_ack}, 32'b10);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        check("tie2_m1_acks",  {30'd0, m0_ack, m1_ack}, 32'b01);
        drive_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Out of range: beyond RAM depth
        drive_m0(1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
        tick();
        check("oor_ram_en",    {31'd0, ram_en},    32'd0);
        tick();
        check("oor_ack_err",   {30'd0, m0_ack, m0_err}, 32'b11);
        check("oor_rdata",     m0_rdata,           32'd0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Out of range: misaligned
        drive_m0(1'b1, 1'b0, 32'h0000_0002, 32'h0, 4'h0);
        tick();
        check("mis_ram_en",    {31'd0, ram_en},    32'd0);
        tick();
        check("mis_ack_err",   {30'd0, m0_ack, m0_err}, 32'b11);
        check("mis_rdata",     m0_rdata,           32'd0);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Reset in the ACCESS cycle of a write to 0x18
        drive_m0(1'b1, 1'b1, 32'h18, 32'h0000_0055, 4'hF);
        tick();
        check("rma_ram_en",    {31'd0, ram_en},    32'd1);
        rst = 1'b1;
        drive_m0(1'b1, 1'b0, 32'h18, 32'h0, 4'h0);
        tick();
        check("rma_no_ack",    {30'd0, m0_ack, m1_ack}, 32'b00);
        check("rma_ram_en",    {31'd0, ram_en},    32'd0);
        check("rma_ram_we",    {28'd0, ram_we},    32'd0);
        check("rma_ram_addr",  {22'd0, ram_addr},  32'd0);
        check("rma_ram_wdata", ram_wdata,          32'd0);
        rst = 1'b0;
        tick();
        check("rma_re_access", {31'd0, ram_en},    32'd1);
        check("rma_re_addr",   {22'd0, ram_addr},  32'd6);
        tick();
        check("rma_re_ack",    {31'd0, m0_ack},    32'd1);
        check("rma_write_kept", m0_rdata,          32'h0000_0055);
        drive_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        check("end_idle",      {31'd0, m0_ack},    32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
